uart_tx_fifo_drain: RTL and testbench

UART transmitter stage that sits directly downstream of the synchronous byte FIFO in the axis_uart path. It pops bytes from the FIFO's first-word-fall-through read port and serialises each one onto txd as a standard asynchronous frame: start bit, LSB-first data, optional parity, then stop bit(s). Frames are sent back-to-back with zero idle gap while the FIFO is non-empty.

---
 rtl/uart_tx_fifo_drain.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a first-word-fall-through byte FIFO and
// serialises each byte as start / LSB-first data / optional parity / stop bits.
module uart_tx_fifo_drain #(
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    output logic              txd,
    output logic              busy
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DWIDTH - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
    localparam logic              PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                stop_q, stop_d;
    logic [DWIDTH-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                pop_c;
    logic                baud_end_c;

    assign baud_end_c = (baud_q == BAUD_LAST);

    // Held low during reset so a non-empty FIFO is not popped while the block is held.
    assign fifo_ren = pop_c & rstn;
    assign txd      = txd_q;
    assign busy     = busy_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop_c    = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_end_c ? '0 : BAUD_W'(baud_q + 1'b1);
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                stop_d = 1'b0;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                bit_d = '0;
                if (baud_end_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        stop_d  = 1'b0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = BIT_W'(bit_q + 1'b1);
                    end
                end
            end
            PARITY: begin
                if (baud_end_c) begin
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_end_c) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d = 1'b0;
                        // Chain straight into the next frame when data is waiting.
                        if (!fifo_empty) begin
                            pop_c   = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop_c) begin
            shift_d  = fifo_data;
            parity_d = (^fifo_data) ^ PAR_INV;
        end

        // Line level is decoded from the next state so txd comes straight off a flop.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = parity_d;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: four instances at CLKS_PER_BIT=4 covering
// plain 8N1, even parity, odd parity and two stop bits, each fed by a small FIFO model.
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [7:0] data  [4];
    logic       empty [4];
    logic       ren   [4];
    logic       txd   [4];
    logic       busy  [4];

    logic [7:0] mem [4][8];
    int         rd  [4] = '{default: 0};
    int         wr  [4] = '{default: 0};
    logic       pend[4];

    int tests = 0;
    int fails = 0;

    uart_tx_fifo_drain #(.DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rstn(rstn), .fifo_data(data[0]), .fifo_empty(empty[0]),
        .fifo_ren(ren[0]), .txd(txd[0]), .busy(busy[0]));
    uart_tx_fifo_drain #(.DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rstn(rstn), .fifo_data(data[1]), .fifo_empty(empty[1]),
        .fifo_ren(ren[1]), .txd(txd[1]), .busy(busy[1]));
    uart_tx_fifo_drain #(.DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rstn(rstn), .fifo_data(data[2]), .fifo_empty(empty[2]),
        .fifo_ren(ren[2]), .txd(txd[2]), .busy(busy[2]));
    uart_tx_fifo_drain #(.DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rstn(rstn), .fifo_data(data[3]), .fifo_empty(empty[3]),
        .fifo_ren(ren[3]), .txd(txd[3]), .busy(busy[3]));

    // FIFO model: head word / empty flag derived from the read and write pointers.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (rd[i] == wr[i]);
            data[i]  = empty[i] ? 8'h00 : mem[i][rd[i][2:0]];
        end
    end

    // Pop strobe is sampled mid-cycle and applied just after the following edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) pend[i] = ren[i];
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) if (pend[i]) rd[i] = rd[i] + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push1(input int idx, input logic [7:0] b);
        @(posedge clk); #2;
        mem[idx][wr[idx][2:0]] = b;
        wr[idx] = wr[idx] + 1;
    endtask

    task automatic push2(input int idx, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #2;
        mem[idx][wr[idx][2:0]] = a;
        mem[idx][3'(wr[idx] + 1)] = b;
        wr[idx] = wr[idx] + 2;
    endtask

    task automatic wait_ren(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (ren[idx]) ok = 1'b1;
        end
    endtask

    task automatic capture(input int idx, input int len, output logic [127:0] s,
                           output int nbusy, output int nren, output int ren_at);
        s = '1; nbusy = 0; nren = 0; ren_at = -1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            s[i] = txd[idx];
            if (busy[idx]) nbusy++;
            if (ren[idx]) begin nren++; ren_at = i; end
        end
    endtask

    // Expected line waveform, one sample per clock, frame starting at sample 'base'.
    function automatic logic [127:0] put_frame(input logic [127:0] v, input logic [7:0] b,
                                               input int par_en, input int odd,
                                               input int stops, input int base);
        logic [127:0] r = v;
        logic bits[16];
        int n = 0;
        bits[n++] = 1'b0;
        for (int k = 0; k < 8; k++) bits[n++] = b[k];
        if (par_en != 0) bits[n++] = (^b) ^ (odd != 0);
        for (int k = 0; k < stops; k++) bits[n++] = 1'b1;
        for (int k = 0; k < n; k++)
            for (int c = 0; c < CPB; c++) r[base + k*CPB + c] = bits[k];
        return r;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({txd[i], busy[i], ren[i]} !== 3'b100) begin
                fails++;
                $display("FAIL reset_state inst%0d: txd/busy/ren=%b%b%b required 100", i, txd[i], busy[i], ren[i]);
            end
        end
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_idle_empty();
        int bad = 0;
        repeat (200) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (ren[i] !== 1'b0 || txd[i] !== 1'b1 || busy[i] !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_empty: %0d bad samples, required 0", bad);
        end
    endtask

    task automatic test_single();
        bit ok; logic [127:0] s, e; int nb, nr, ra;
        push1(0, 8'h55);
        wait_ren(0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_pop: no fifo_ren seen, required one"); end
        capture(0, 40, s, nb, nr, ra);
        e = put_frame('1, 8'h55, 0, 0, 1, 0);
        tests++;
        if (s !== e) begin fails++; $display("FAIL single_wave: got %h required %h", s, e); end
        tests++;
        if (nb != 40) begin fails++; $display("FAIL single_busy: busy cycles %0d required 40", nb); end
        tests++;
        if (nr != 0) begin fails++; $display("FAIL single_extra_pop: %0d extra fifo_ren, required 0", nr); end
        @(negedge clk);
        tests++;
        if ({txd[0], busy[0]} !== 2'b10) begin
            fails++;
            $display("FAIL single_idle: txd/busy=%b%b required 10", txd[0], busy[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [127:0] s, e; int nb, nr, ra; logic [7:0] d1, d2;
        push2(0, 8'hA5, 8'h3C);
        wait_ren(0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_pop: no fifo_ren seen, required one"); end
        capture(0, 80, s, nb, nr, ra);
        e = put_frame('1, 8'hA5, 0, 0, 1, 0);
        e = put_frame(e, 8'h3C, 0, 0, 1, 40);
        tests++;
        if (s !== e) begin fails++; $display("FAIL b2b_wave: got %h required %h", s, e); end
        tests++;
        if (nb != 80) begin fails++; $display("FAIL b2b_busy: busy cycles %0d required 80", nb); end
        tests++;
        if (nr != 1 || ra != 39) begin
            fails++;
            $display("FAIL b2b_pop_spacing: pops %0d at %0d required 1 at 39", nr, ra);
        end
        for (int b = 0; b < 8; b++) begin
            d1[b] = s[CPB + CPB*b + 2];
            d2[b] = s[40 + CPB + CPB*b + 2];
        end
        tests++;
        if (d1 !== 8'hA5 || d2 !== 8'h3C) begin
            fails++;
            $display("FAIL b2b_decode: got %h %h required a5 3c", d1, d2);
        end
        @(negedge clk);
    endtask

    task automatic test_parity();
        bit ok; logic [127:0] s, e; int nb, nr, ra;
        for (int p = 1; p <= 2; p++) begin
            push1(p, 8'h07);
            wait_ren(p, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL parity_pop inst%0d: no fifo_ren seen", p); end
            capture(p, 44, s, nb, nr, ra);
            e = put_frame('1, 8'h07, 1, p - 1, 1, 0);
            tests++;
            if (s !== e) begin fails++; $display("FAIL parity_wave inst%0d: got %h required %h", p, s, e); end
            tests++;
            if (s[38] !== ((p == 1) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL parity_bit inst%0d: got %b required %b", p, s[38], (p == 1));
            end
            @(negedge clk);
            tests++;
            if (nb != 44 || busy[p] !== 1'b0) begin
                fails++;
                $display("FAIL parity_len inst%0d: busy cycles %0d then busy=%b required 44 then 0", p, nb, busy[p]);
            end
        end
    endtask

    task automatic test_stop2();
        bit ok; logic [127:0] s, e; int nb, nr, ra;
        push2(3, 8'hFF, 8'h00);
        wait_ren(3, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL stop2_pop: no fifo_ren seen"); end
        capture(3, 88, s, nb, nr, ra);
        e = put_frame('1, 8'hFF, 0, 0, 2, 0);
        e = put_frame(e, 8'h00, 0, 0, 2, 44);
        tests++;
        if (s !== e) begin fails++; $display("FAIL stop2_wave: got %h required %h", s, e); end
        tests++;
        if (s[43] !== 1'b1 || s[44] !== 1'b0 || ra != 43) begin
            fails++;
            $display("FAIL stop2_next_start: s43=%b s44=%b pop_at=%0d required 1 0 43", s[43], s[44], ra);
        end
        tests++;
        if (nb != 88) begin fails++; $display("FAIL stop2_busy: busy cycles %0d required 88", nb); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; logic [127:0] s, e; int nb, nr, ra;
        push2(0, 8'h81, 8'h42);
        wait_ren(0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rmid_pop: no fifo_ren seen"); end
        repeat (17) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        tests++;
        if ({txd[0], busy[0], ren[0]} !== 3'b100) begin
            fails++;
            $display("FAIL rmid_async: txd/busy/ren=%b%b%b required 100", txd[0], busy[0], ren[0]);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;
        wait_ren(0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rmid_repop: no fifo_ren after release"); end
        capture(0, 40, s, nb, nr, ra);
        e = put_frame('1, 8'h42, 0, 0, 1, 0);
        tests++;
        if (s !== e) begin fails++; $display("FAIL rmid_wave: got %h required %h", s, e); end
        @(negedge clk);
        tests++;
        if (busy[0] !== 1'b0 || empty[0] !== 1'b1) begin
            fails++;
            $display("FAIL rmid_end: busy=%b empty=%b required 0 1", busy[0], empty[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++) mem[i][j] = 8'h00;
        test_reset();
        test_idle_empty();
        test_single();
        test_back_to_back();
        test_parity();
        test_stop2();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
